// File: rtl/uart_image_rx.sv
// rtl/uart_image_rx.sv - 8N1 UART receiver and image packet parser (sync, height, width, RGB pixels)
module uart_image_rx #(
    parameter int          CLK_FREQ     = 100000000,
    parameter int          BAUD         = 115200,
    parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_in,
    output logic [7:0] data_out_r,
    output logic [7:0] data_out_g,
    output logic [7:0] data_out_b,
    output logic       pixel_valid,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [7:0] height,
    output logic [7:0] width,
    output logic       frame_start,
    output logic       frame_done,
    output logic       frame_err,
    output logic       size_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [2:0] {P_SYNC, P_H, P_W, P_R, P_G, P_B} p_state_t;

    logic            sync1, rx_s;
    rx_state_t       rx_state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [7:0]      rx_byte;
    logic            byte_strobe;

    p_state_t        p_state;
    logic [7:0]      h_lat, r_lat, g_lat, xc, yc;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state    <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_byte     <= '0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (!rx_s) begin
                        rx_state <= START;
                        cnt      <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) rx_state <= STOP;
                        else                 bit_idx  <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        rx_state <= IDLE;
                        if (rx_s) begin
                            byte_strobe <= 1'b1;
                            rx_byte     <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state     <= P_SYNC;
            h_lat       <= '0;
            r_lat       <= '0;
            g_lat       <= '0;
            xc          <= '0;
            yc          <= '0;
            data_out_r  <= '0;
            data_out_g  <= '0;
            data_out_b  <= '0;
            x           <= '0;
            y           <= '0;
            height      <= '0;
            width       <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            size_err    <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            size_err    <= 1'b0;
            // A bad stop bit aborts whatever packet was in progress.
            if (frame_err) begin
                p_state <= P_SYNC;
            end else if (byte_strobe) begin
                case (p_state)
                    P_SYNC: if (rx_byte == SYNC_BYTE) p_state <= P_H;
                    P_H: begin
                        h_lat   <= rx_byte;
                        p_state <= P_W;
                    end
                    P_W: begin
                        if (h_lat == 8'd0 || rx_byte == 8'd0) begin
                            size_err <= 1'b1;
                            p_state  <= P_SYNC;
                        end else begin
                            height      <= h_lat;
                            width       <= rx_byte;
                            frame_start <= 1'b1;
                            xc          <= '0;
                            yc          <= '0;
                            p_state     <= P_R;
                        end
                    end
                    P_R: begin
                        r_lat   <= rx_byte;
                        p_state <= P_G;
                    end
                    P_G: begin
                        g_lat   <= rx_byte;
                        p_state <= P_B;
                    end
                    P_B: begin
                        data_out_r  <= r_lat;
                        data_out_g  <= g_lat;
                        data_out_b  <= rx_byte;
                        x           <= xc;
                        y           <= yc;
                        pixel_valid <= 1'b1;
                        p_state     <= P_R;
                        if (xc == width - 8'd1) begin
                            xc <= '0;
                            if (yc == height - 8'd1) begin
                                frame_done <= 1'b1;
                                p_state    <= P_SYNC;
                            end else begin
                                yc <= yc + 8'd1;
                            end
                        end else begin
                            xc <= xc + 8'd1;
                        end
                    end
                    default: p_state <= P_SYNC;
                endcase
            end
        end
    end
endmodule
